// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw push-buttons in, conditioned levels/pulses/event out.
interface button_conditioner_if;
  logic       BTNC;
  logic       BTNU;
  logic       BTND;
  logic       BTNR;
  logic       BTNL;
  logic [4:0] held;      // {C,U,D,L,R}
  logic [4:0] press;     // {C,U,D,L,R}
  logic       evtValid;
  logic [2:0] evtCode;

  // board/driver side
  modport master (
    output BTNC, BTNU, BTND, BTNR, BTNL,
    input  held, press, evtValid, evtCode
  );

  // conditioner side
  modport slave (
    input  BTNC, BTNU, BTND, BTNR, BTNL,
    output held, press, evtValid, evtCode
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: per-button sync + debounce + press detect, hold-to-repeat
// on direction buttons, and a registered priority event code for the game FSM.

// One button: 2-flop sync, debounce counter, optional IDLE/DELAY/REPEAT auto-repeat.
module button_lane #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter bit RPT             = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RT_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  rpt_state_t       state, state_nxt;
  logic             flip, rise, fall, rpt_pulse;

  // level flips on this edge; rise/fall are the edges the debounced level changes
  assign flip = (s2 != level) && (db_cnt == DB_LAST);
  assign rise = flip & s2;
  assign fall = flip & ~s2;

  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // debounce: level follows s2 only after it has differed for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk) begin
    if (reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (s2 == level) begin
      db_cnt <= '0;
    end else if (flip) begin
      level  <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // repeat FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

  // repeat FSM next state; a release edge wins over a due repeat pulse
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    rpt_pulse   = 1'b0;
    if (fall) begin
      state_nxt   = IDLE;
      rpt_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise && RPT) begin
            state_nxt   = DELAY;
            rpt_cnt_nxt = '0;
          end
        end
        DELAY: begin
          if (rpt_cnt == DLY_LAST) begin
            rpt_pulse   = 1'b1;
            rpt_cnt_nxt = '0;
            state_nxt   = REPEAT;
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rpt_cnt == RT_LAST) begin
            rpt_pulse   = 1'b1;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end
      endcase
    end
  end

  // registered one-cycle press: initial rise or auto-repeat
  always_ff @(posedge clk) begin
    if (reset) press <= 1'b0;
    else       press <= rise | rpt_pulse;
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter int REPEAT_ENABLE   = 1,
  parameter int CNT_W           = 16
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);
  localparam int NUM_BTN = 5;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [2:0]         code_nxt;

  // bit order {C,U,D,L,R}; bit 4 (centre) never repeats
  assign raw = {bus.BTNC, bus.BTNU, bus.BTND, bus.BTNL, bus.BTNR};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    localparam bit RPT = (REPEAT_ENABLE != 0) && (i != NUM_BTN - 1);
    button_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .RPT            (RPT),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign bus.held  = level;
  assign bus.press = press;

  // priority C > U > D > L > R; lower simultaneous presses drop out of the code only
  always_comb begin
    code_nxt = 3'd0;
    if      (press[4]) code_nxt = 3'd1;
    else if (press[3]) code_nxt = 3'd2;
    else if (press[2]) code_nxt = 3'd3;
    else if (press[1]) code_nxt = 3'd4;
    else if (press[0]) code_nxt = 3'd5;
  end

  // event register, one cycle behind press
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.evtValid <= 1'b0;
      bus.evtCode  <= 3'd0;
    end else begin
      bus.evtValid <= |press;
      bus.evtCode  <= code_nxt;
    end
  end
endmodule
